// File: rtl/seq_divider_if.sv
// ---------------------------------------------------------------------------
// seq_divider_if
//   Board-side bundle for the sequential divider lab block.
//   Controls (driven by the board / bench, "master"):
//     Run        active-low start button, one division per press
//     LoadD      active-low divisor load strobe
//     S[7:0]     slider switches: dividend at start, divisor on LoadD
//   Results (driven by the divider, "slave"):
//     Qval/Rval  quotient / remainder registers
//     Busy       division in progress
//     DivByZero  last division had a zero divisor
//     QhexU/QhexL/RhexU/RhexL  registered active-low 7-segment glyphs
// ---------------------------------------------------------------------------
interface seq_divider_if;
  logic       Run;
  logic       LoadD;
  logic [7:0] S;
  logic [7:0] Qval;
  logic [7:0] Rval;
  logic       Busy;
  logic       DivByZero;
  logic [6:0] QhexU;
  logic [6:0] QhexL;
  logic [6:0] RhexU;
  logic [6:0] RhexL;

  modport master (
    output Run, LoadD, S,
    input  Qval, Rval, Busy, DivByZero, QhexU, QhexL, RhexU, RhexL
  );

  modport slave (
    input  Run, LoadD, S,
    output Qval, Rval, Busy, DivByZero, QhexU, QhexL, RhexU, RhexL
  );
endinterface

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Sequential 8-bit restoring divider, one quotient bit per clock.
//   A Run press in IDLE latches the dividend from S and runs 8 trial
//   subtractions against the divisor held in D; results sit in Qval/Rval
//   until the next press. Divide-by-zero short-circuits to Q=FF, R=dividend.
//
//   Ports:
//     Clk    system clock (50 MHz)
//     Reset  synchronous, active-low reset
//     bus    seq_divider_if.slave (Run, LoadD, S in; Qval, Rval, Busy,
//            DivByZero and four 7-segment glyph registers out)
//
//   Build option:
//     SIGNED_DIV_EN  two's-complement operands; magnitudes run through the
//                    unsigned core and a FIXUP cycle restores signs
//                    (truncation toward zero). Undefined: unsigned only.
// ---------------------------------------------------------------------------
module seq_divider #(
  parameter int unsigned WIDTH = 8   // only 8 is supported (hex wiring)
) (
  input logic        Clk,
  input logic        Reset,
  seq_divider_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_DONE  = 2'd2
`ifdef SIGNED_DIV_EN
    ,S_FIXUP = 2'd3
`endif
  } state_e;

  localparam logic [6:0] GLYPH_ZERO = 7'b1000000;

  state_e           state_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic [2:0]       cnt_q;
  logic             busy_q;
  logic             dbz_q;
  logic [6:0]       qhex_u_q, qhex_l_q, rhex_u_q, rhex_l_q;

  logic [WIDTH-1:0] dvd_mag_d;  // dividend magnitude entering the core
  logic [WIDTH-1:0] dvs_mag_d;  // divisor magnitude used by every trial
  logic [WIDTH:0]   trial_d;    // {R,Q[7]} - D; bit 8 set means "does not fit"

`ifdef SIGNED_DIV_EN
  logic sign_n_q;  // dividend sign, also the remainder's sign
  logic sign_d_q;  // divisor sign

  assign dvd_mag_d = bus.S[WIDTH-1] ? (~bus.S + 8'd1) : bus.S;
  assign dvs_mag_d = d_q[WIDTH-1]   ? (~d_q + 8'd1)   : d_q;
`else
  assign dvd_mag_d = bus.S;
  assign dvs_mag_d = d_q;
`endif

  // R stays below D between steps, so the difference never exceeds 8 bits
  // when it is non-negative and bit 8 is a clean borrow flag.
  assign trial_d = {r_q, q_q[WIDTH-1]} - {1'b0, dvs_mag_d};

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    // NOTE: the default arm makes the decode total, so no storage is implied.
    unique case (nib)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // NOTE: reset is sampled on the clock edge, so it lives inside the clocked
  // block rather than in the sensitivity list.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      // NOTE: every register update uses <= so all of them see pre-edge values.
      state_q  <= S_IDLE;
      d_q      <= '0;
      q_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      dbz_q    <= 1'b0;
      qhex_u_q <= GLYPH_ZERO;
      qhex_l_q <= GLYPH_ZERO;
      rhex_u_q <= GLYPH_ZERO;
      rhex_l_q <= GLYPH_ZERO;
`ifdef SIGNED_DIV_EN
      sign_n_q <= 1'b0;
      sign_d_q <= 1'b0;
`endif
    end else begin
      // Display stage tracks Q/R one cycle behind, every cycle.
      qhex_u_q <= seg7(q_q[7:4]);
      qhex_l_q <= seg7(q_q[3:0]);
      rhex_u_q <= seg7(r_q[7:4]);
      rhex_l_q <= seg7(r_q[3:0]);

      unique case (state_q)
        S_IDLE: begin
          if (!bus.LoadD) begin
            d_q <= bus.S;           // load wins over a simultaneous Run
          end else if (!bus.Run) begin
            cnt_q <= '0;
            if (d_q == '0) begin
              q_q     <= 8'hFF;
              r_q     <= bus.S;     // raw dividend, signed build included
              dbz_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              q_q     <= dvd_mag_d;
              r_q     <= '0;
              dbz_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= S_ITER;
`ifdef SIGNED_DIV_EN
              sign_n_q <= bus.S[WIDTH-1];
              sign_d_q <= d_q[WIDTH-1];
`endif
            end
          end
        end

        S_ITER: begin
          if (!trial_d[WIDTH]) begin
            r_q <= trial_d[WIDTH-1:0];
            q_q <= {q_q[WIDTH-2:0], 1'b1};
          end else begin
            r_q <= {r_q[WIDTH-2:0], q_q[WIDTH-1]};
            q_q <= {q_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
`ifdef SIGNED_DIV_EN
            state_q <= S_FIXUP;
`else
            busy_q  <= 1'b0;
            state_q <= S_DONE;
`endif
          end
        end

`ifdef SIGNED_DIV_EN
        S_FIXUP: begin
          // Quotient negative iff signs differ; remainder follows dividend.
          if (sign_n_q ^ sign_d_q) q_q <= ~q_q + 8'd1;
          if (sign_n_q)            r_q <= ~r_q + 8'd1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
`endif

        S_DONE: begin
          // Wait for the button to be released: one division per press.
          if (bus.Run) state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.Qval      = q_q;
  assign bus.Rval      = r_q;
  assign bus.Busy      = busy_q;
  assign bus.DivByZero = dbz_q;
  assign bus.QhexU     = qhex_u_q;
  assign bus.QhexL     = qhex_l_q;
  assign bus.RhexU     = rhex_u_q;
  assign bus.RhexL     = rhex_l_q;

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
//   Self-checking bench for seq_divider. A transaction-level model computes
//   each result with plain / and %, tracks latency as a step count and
//   predicts the glyph registers one cycle behind; a negedge process compares
//   the DUT against it whenever the outputs are defined. Directed sequences
//   add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_seq_divider;

  logic Clk = 1'b0;
  logic Reset;

  seq_divider_if bus ();

  seq_divider #(.WIDTH(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #10 Clk = ~Clk;

`ifdef SIGNED_DIV_EN
  localparam int STEPS = 9;
`else
  localparam int STEPS = 8;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[n];
  endfunction

  function automatic void divide(input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] q, output logic [7:0] r);
`ifdef SIGNED_DIV_EN
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    q  = 8'(sa / sb);
    r  = 8'(sa % sb);
`else
    q = a / b;
    r = a % b;
`endif
  endfunction

  // ---------------- behavioural model ----------------
  typedef enum {P_IDLE, P_RUN, P_DONE} phase_e;
  phase_e     m_phase = P_IDLE;
  bit         m_valid = 1'b0;   // set once the first reset has been seen
  bit         m_known = 1'b0;   // Q/R outputs defined (not mid-division)
  bit         m_hex_ok = 1'b0;
  int         m_left = 0;
  logic [7:0] m_d, m_q, m_r;
  logic       m_busy, m_dbz;
  logic [6:0] m_qu, m_ql, m_ru, m_rl;

  always @(posedge Clk) begin
    if (!Reset) begin
      m_valid = 1'b1; m_known = 1'b1; m_hex_ok = 1'b1;
      m_phase = P_IDLE;
      m_d = 8'h00; m_q = 8'h00; m_r = 8'h00; m_busy = 1'b0; m_dbz = 1'b0;
      m_qu = glyph(4'h0); m_ql = glyph(4'h0); m_ru = glyph(4'h0); m_rl = glyph(4'h0);
    end else if (m_valid) begin
      m_hex_ok = m_known;
      m_qu = glyph(m_q[7:4]); m_ql = glyph(m_q[3:0]);
      m_ru = glyph(m_r[7:4]); m_rl = glyph(m_r[3:0]);
      case (m_phase)
        P_IDLE:
          if (!bus.LoadD) m_d = bus.S;
          else if (!bus.Run) begin
            if (m_d == 8'h00) begin
              m_q = 8'hFF; m_r = bus.S; m_dbz = 1'b1; m_phase = P_DONE;
            end else begin
              divide(bus.S, m_d, m_q, m_r);
              m_dbz = 1'b0; m_busy = 1'b1; m_known = 1'b0;
              m_left = STEPS; m_phase = P_RUN;
            end
          end
        P_RUN: begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 1'b0; m_known = 1'b1; m_phase = P_DONE;
          end
        end
        default:
          if (bus.Run) m_phase = P_IDLE;
      endcase
    end
  end

  // ---------------- every-cycle compare ----------------
  always @(negedge Clk) begin
    if (m_valid) begin
      check("busy", bus.Busy, m_busy);
      if (m_known) begin
        check("qval", bus.Qval, m_q);
        check("rval", bus.Rval, m_r);
        check("dbz", bus.DivByZero, m_dbz);
      end
      if (m_hex_ok) begin
        check("qhexu", bus.QhexU, m_qu);
        check("qhexl", bus.QhexL, m_ql);
        check("rhexu", bus.RhexU, m_ru);
        check("rhexl", bus.RhexL, m_rl);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic load_d(input logic [7:0] v);
    bus.LoadD = 1'b0; bus.S = v;
    @(negedge Clk);
    bus.LoadD = 1'b1;
  endtask

  // One short press; S and LoadD are disturbed after E0 to show they are
  // ignored by the running division. Returns the number of busy cycles.
  task automatic press(input logic [7:0] dvd, output int busy_cycles);
    bit done;
    bus.S = dvd; bus.Run = 1'b0;
    @(negedge Clk);                 // just after E0
    bus.Run = 1'b1; bus.S = ~dvd; bus.LoadD = 1'b0;
    busy_cycles = 0;
    done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!bus.Busy) begin done = 1'b1; break; end
      busy_cycles++;
      @(negedge Clk);
      bus.LoadD = 1'b1;
    end
    bus.LoadD = 1'b1;
    if (!done) begin
      checks++; errors++;
      $display("FAIL busy_timeout: Busy still high after 30 cycles");
    end
    repeat (2) @(negedge Clk);      // let the glyph stage settle
  endtask

  int nb;

  initial begin
    Reset = 1'b0; bus.Run = 1'b1; bus.LoadD = 1'b1; bus.S = 8'h00;

    // 1: reset values
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    check("rst_q", bus.Qval, 8'h00);
    check("rst_r", bus.Rval, 8'h00);
    check("rst_busy", bus.Busy, 1'b0);
    check("rst_dbz", bus.DivByZero, 1'b0);
    check("rst_qhexu", bus.QhexU, 7'b1000000);
    check("rst_rhexl", bus.RhexL, 7'b1000000);

    // 2: 100/7 with Run held for 20 cycles
    load_d(8'd7);
    bus.S = 8'd100; bus.Run = 1'b0;
    nb = 0;
    repeat (20) begin
      @(negedge Clk);
      if (bus.Busy) nb++;
    end
    check("held_busy_cycles", nb, STEPS);
    bus.Run = 1'b1;
    repeat (2) @(negedge Clk);
    check("q_100_7", bus.Qval, 8'h0E);
    check("r_100_7", bus.Rval, 8'h02);
    check("model_q_100_7", m_q, 8'h0E);
    check("qhexl_E", bus.QhexL, 7'b0000110);
    check("rhexl_2", bus.RhexL, 7'b0100100);
    check("idle_after_release", bus.Busy, 1'b0);

    // 3: boundary operands
    load_d(8'h01);
    press(8'hFF, nb);
    check("busy_cycles_ff_1", nb, STEPS);
    check("q_ff_1", bus.Qval, 8'hFF);
    check("r_ff_1", bus.Rval, 8'h00);
    load_d(8'd10);
    press(8'd3, nb);
    check("q_3_10", bus.Qval, 8'h00);
    check("r_3_10", bus.Rval, 8'h03);

    // 4: divide by zero
    load_d(8'h00);
    bus.S = 8'd5; bus.Run = 1'b0;
    @(negedge Clk);
    check("dbz_flag", bus.DivByZero, 1'b1);
    check("dbz_q", bus.Qval, 8'hFF);
    check("dbz_r", bus.Rval, 8'h05);
    check("dbz_busy", bus.Busy, 1'b0);
    bus.Run = 1'b1;
    repeat (3) @(negedge Clk);
    check("model_dbz_r", m_r, 8'h05);

    // 5: reset at E4 of 200/3, then a clean 200/3
    load_d(8'd3);
    bus.S = 8'd200; bus.Run = 1'b0;
    @(negedge Clk);                 // after E0
    bus.Run = 1'b1;
    repeat (3) @(negedge Clk);      // after E1..E3
    Reset = 1'b0;
    @(negedge Clk);                 // after E4
    Reset = 1'b1;
    check("abort_q", bus.Qval, 8'h00);
    check("abort_r", bus.Rval, 8'h00);
    check("abort_busy", bus.Busy, 1'b0);
    check("abort_qhexl", bus.QhexL, 7'b1000000);
    repeat (3) @(negedge Clk);
    check("abort_stays_idle", bus.Busy, 1'b0);
    load_d(8'd3);
    press(8'd200, nb);
`ifdef SIGNED_DIV_EN
    check("q_200_3", bus.Qval, 8'hEE);
    check("r_200_3", bus.Rval, 8'hFE);
`else
    check("q_200_3", bus.Qval, 8'h42);
    check("r_200_3", bus.Rval, 8'h02);
`endif

`ifdef SIGNED_DIV_EN
    // 6: signed cases
    load_d(8'h02);
    press(8'hF9, nb);
    check("busy_cycles_m7_2", nb, 9);
    check("q_m7_2", bus.Qval, 8'hFD);
    check("r_m7_2", bus.Rval, 8'hFF);
    load_d(8'hFF);
    press(8'h80, nb);
    check("q_m128_m1", bus.Qval, 8'h80);
    check("r_m128_m1", bus.Rval, 8'h00);
    load_d(8'hFD);
    press(8'd7, nb);
    check("q_7_m3", bus.Qval, 8'hFE);
    check("r_7_m3", bus.Rval, 8'h01);
`endif

    // a few more model-checked patterns
    load_d(8'd13);
    press(8'hC5, nb);
    load_d(8'hF0);
    press(8'h0F, nb);
    load_d(8'h80);
    press(8'h7F, nb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Sequential 8-bit restoring divider, the inverse datapath of the team's shift-add multiplier. It is driven by the same board controls: slider switches S, a load button and a Run button. It computes quotient and remainder one bit per clock and drives Qval/Rval plus four registered seven-segment outputs. It is the top-level lab block for the divide experiment.

Parameters:
WIDTH, 8, operand/result width; only 8 is supported; the hex wiring assumes 8.

Ports:
Clk  input  1  system clock (50 MHz).
Reset  input  1  synchronous, active-low reset.
Run  input  1  active-low push-button; starts one division per press.
LoadD  input  1  active-low; loads divisor from S.
S  input  8  slider switches; dividend at start, divisor on LoadD.
Qval  output  8  quotient register.
Rval  output  8  remainder register.
Busy  output  1  high while a division is in progress.
DivByZero  output  1  set when the last division had divisor 0.
QhexU, QhexL, RhexU, RhexL  output  7 each  registered active-low segment patterns for Qval/Rval nibbles.

Behaviour:
- Clock and reset: reset is Reset, synchronous, active-low; the clock is Clk. All state changes on posedge Clk.
- Reset values: D=0, Qval=0, Rval=0, Busy=0, DivByZero=0, cnt=0, state=IDLE, all hex outputs = glyph "0" (7'b1000000).
- Reset has priority over everything, including mid-ITER. The operation is abandoned and nothing resumes.
- Internal registers:
  - D[7:0]: divisor.
  - Q[7:0] and R[7:0]: drive Qval and Rval directly.
  - cnt[2:0]: iteration counter.
- States: IDLE, ITER, DONE.
- IDLE:
  - LoadD==0 loads D<=S. LoadD beats Run in the same cycle; Run is ignored that cycle.
  - Otherwise Run==0 starts a division on this edge E0: Q<=S, R<=0, cnt<=0, DivByZero<=0.
  - If D==0 at start: Q<=8'hFF, R<=S, DivByZero<=1, go to DONE. Busy stays 0.
  - If D!=0 at start: Busy<=1, go to ITER.
- ITER, one step per cycle:
  - Compute the 9-bit trial diff = {R,Q[7]} - {1'b0,D}.
  - If diff[8]==0: R<=diff[7:0], Q<={Q[6:0],1}.
  - Else: R<={R[6:0],Q[7]}, Q<={Q[6:0],0}.
  - cnt increments each step. At cnt==7 the step is the last one: Busy<=0, go to DONE.
- Latency: the 8 steps occur at edges E1..E8. Qval, Rval and Busy=0 are valid after E8. Hex outputs are valid after E9 (one register stage).
- DONE: hold all results. Return to IDLE only when Run==1, so a held Run button gives exactly one division per press.
- LoadD is ignored outside IDLE. S changes after E0 do not affect the running division.
- Hex outputs: combinational nibble-to-glyph of Q/R, registered every cycle. Glyphs are active-low, covering 0-F.

Optional Feature:
Macro SIGNED_DIV_EN.
- Defined:
  - Operands are two's complement.
  - At E0, magnitudes |S| and |D| enter the unsigned core. Dividend and divisor signs are latched.
  - A FIXUP state follows ITER and adds one cycle: Busy falls at E9, hex valid at E10.
  - In FIXUP, Q is negated if the signs differ, and R takes the dividend's sign. This is truncation toward zero.
  - -128/-1 yields Q=8'h80, R=0 (wraps; no flag).
  - Divide-by-zero behaves as in unsigned mode: Q=FF, R=dividend.
- Undefined: unsigned only, no FIXUP state, sign logic absent.

Test Plan:
1. Reset low for 2 cycles, then high -> Qval=0, Rval=0, Busy=0, DivByZero=0, all hex=7'b1000000.
2. LoadD with S=7; Run with S=100 held 20 cycles -> Busy high 8 cycles; Qval=0x0E, Rval=0x02; exactly one operation; IDLE after Run releases.
3. D=0x01, dividend 0xFF -> Q=0xFF, R=0x00. D=10, dividend 3 -> Q=0x00, R=0x03.
4. D=0, dividend 5 -> DivByZero=1, Q=0xFF, R=0x05 one cycle after E0; Busy never asserts.
5. Start 200/3, assert Reset at E4 -> next cycle all outputs at reset values, state IDLE; a new 200/3 then gives Q=0x42, R=0x02.
6. With SIGNED_DIV_EN: -7/2 (S=0xF9, D=0x02) -> Q=0xFD, R=0xFF, Busy falls at E9. -128/-1 -> Q=0x80, R=0x00.
